// File: rtl/mmio_hub_if.sv
// mmio_hub_if
//   CPU-side data port of the MMIO hub.
//   master modport: the CPU (drives request, address, write data)
//   slave modport : the hub (returns read data, serviced pulse, stall)
//   en            request, level, held by the CPU while mem_wait is high
//   write_enable  1 = write, 0 = read
//   byte_select   address LSB; real byte address = {addr[14:0], byte_select}
//   addr          word address
//   data_in       write data
//   data_out      registered read data
//   serviced_read one-cycle pulse, data_out valid for an MMIO read
//   mem_wait      CPU stall
interface mmio_hub_if;
   logic        en;
   logic        write_enable;
   logic        byte_select;
   logic [15:0] addr;
   logic [15:0] data_in;
   logic [15:0] data_out;
   logic        serviced_read;
   logic        mem_wait;

   modport master (
      output en, write_enable, byte_select, addr, data_in,
      input  data_out, serviced_read, mem_wait
   );

   modport slave (
      input  en, write_enable, byte_select, addr, data_in,
      output data_out, serviced_read, mem_wait
   );
endinterface

// File: rtl/mmio_hub.sv
// mmio_hub
//   Decodes CPU accesses in the region at BASE: four local registers at
//   BASE+0..3, then NUM_SLOTS peripheral windows of 2^SLOT_BITS bytes each
//   starting at BASE+2^SLOT_BITS. Slot accesses can be stretched with
//   slot_wait and are aborted after TIMEOUT wait cycles.
// Ports
//   clk, rst_n   clock / asynchronous active-low reset
//   bus          CPU data port (mmio_hub_if.slave)
//   switches     asynchronous switch inputs (synchronised here)
//   irq          |(irq_status & irq_mask)
//   slot_sel     one-hot slot select while a slot access is active
//   slot_wr/rd   write/read strobes, level while access active
//   slot_offset  byte offset within the slot window
//   slot_wdata   write data to slots (= bus.data_in)
//   slot_rdata   slot k read data at [16k+15:16k]
//   slot_wait    slot k not ready
module mmio_hub #(
   parameter int          NUM_SLOTS   = 4,
   parameter int          SLOT_BITS   = 4,
   parameter logic [15:0] BASE        = 16'hff00,
   parameter int          SW_WIDTH    = 4,
   parameter int          SYNC_STAGES = 2,
   parameter int          TIMEOUT     = 255
) (
   input  logic                   clk,
   input  logic                   rst_n,
   mmio_hub_if.slave              bus,
   input  logic [SW_WIDTH-1:0]    switches,
   output logic                   irq,
   output logic [NUM_SLOTS-1:0]   slot_sel,
   output logic                   slot_wr,
   output logic                   slot_rd,
   output logic [SLOT_BITS-1:0]   slot_offset,
   output logic [15:0]            slot_wdata,
   input  logic [16*NUM_SLOTS-1:0] slot_rdata,
   input  logic [NUM_SLOTS-1:0]   slot_wait
);
   localparam int IDX_W = 3;

   typedef enum logic {IDLE, WAIT} state_t;

   state_t            state_reg, state_next;
   logic [IDX_W-1:0]  idx_reg, idx_next;
   logic              wr_reg, wr_next;
   logic [15:0]       wait_cnt_reg, wait_cnt_next;

   logic [SW_WIDTH-1:0] sync_reg [SYNC_STAGES];
   logic [SW_WIDTH-1:0] sw_prev_reg;
   logic [SW_WIDTH-1:0] irq_status_reg, irq_status_next;
   logic [SW_WIDTH-1:0] irq_mask_reg, irq_mask_next;
   logic                err_to_reg, err_to_next, err_um_reg, err_um_next;
   logic [IDX_W-1:0]    err_idx_reg, err_idx_next;
   logic [15:0]         data_out_reg, data_out_next;
   logic                serviced_reg, serviced_next;

   // ---------------- address decode ----------------
   logic [15:0]      real_addr, offset, slot_num;
   logic             hit, dec_local, dec_slot, dec_unmapped, idle;
   logic [IDX_W-1:0] dec_idx;

   // Gating with rst_n keeps strobes and stall low for the whole reset,
   // even if the CPU is still presenting a request.
   assign real_addr    = {bus.addr[14:0], bus.byte_select};
   assign hit          = bus.en && rst_n && (real_addr >= BASE);
   assign offset       = real_addr - BASE;
   assign slot_num     = offset >> SLOT_BITS;
   assign dec_local    = hit && (offset < 16'd4);
   assign dec_slot     = hit && (slot_num >= 16'd1) && (slot_num <= 16'(NUM_SLOTS));
   assign dec_unmapped = hit && !dec_local && !dec_slot;
   assign dec_idx      = IDX_W'(slot_num - 16'd1);
   assign idle         = (state_reg == IDLE);

   // Slot vectors padded to 8 entries so a 3-bit index never runs off the end.
   logic [15:0] rdata_arr [8];
   logic [7:0]  wait_vec;
   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_pad
         if (gi < NUM_SLOTS) begin : g_used
            assign rdata_arr[gi] = slot_rdata[16*gi +: 16];
            assign wait_vec[gi]  = slot_wait[gi];
         end else begin : g_unused
            assign rdata_arr[gi] = 16'h0000;
            assign wait_vec[gi]  = 1'b0;
         end
      end
   endgenerate

   // ---------------- access FSM ----------------
   logic             acc_active, acc_wr, slot_done, slot_timeout;
   logic [IDX_W-1:0] acc_idx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         idx_reg      <= '0;
         wr_reg       <= 1'b0;
         wait_cnt_reg <= '0;
      end else begin
         state_reg    <= state_next;
         idx_reg      <= idx_next;
         wr_reg       <= wr_next;
         wait_cnt_reg <= wait_cnt_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      idx_next      = idx_reg;
      wr_next       = wr_reg;
      wait_cnt_next = wait_cnt_reg;
      acc_active    = 1'b0;
      acc_idx       = dec_idx;
      acc_wr        = bus.write_enable;
      slot_done     = 1'b0;
      slot_timeout  = 1'b0;
      case (state_reg)
         IDLE: begin
            acc_active = dec_slot;
            if (dec_slot) begin
               if (!wait_vec[dec_idx]) begin
                  slot_done = 1'b1;
               end else begin
                  state_next    = WAIT;
                  idx_next      = dec_idx;
                  wr_next       = bus.write_enable;
                  wait_cnt_next = 16'd1;
               end
            end
         end
         WAIT: begin
            acc_idx    = idx_reg;
            acc_wr     = wr_reg;
            acc_active = bus.en && rst_n;
            if (!acc_active) begin
               state_next = IDLE;          // CPU gave up: silent abort
            end else if (!wait_vec[idx_reg]) begin
               slot_done  = 1'b1;
               state_next = IDLE;
            end else if (wait_cnt_reg == 16'(TIMEOUT)) begin
               slot_timeout = 1'b1;
               state_next   = IDLE;
            end else begin
               wait_cnt_next = wait_cnt_reg + 16'd1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // A timeout ends the access too, so the CPU is released on that cycle.
   assign bus.mem_wait = acc_active && !slot_done && !slot_timeout;
   assign slot_wr      = acc_active && acc_wr;
   assign slot_rd      = acc_active && !acc_wr;
   assign slot_offset  = real_addr[SLOT_BITS-1:0];
   assign slot_wdata   = bus.data_in;

   generate
      for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_sel
         assign slot_sel[gi] = acc_active && (acc_idx == IDX_W'(gi));
      end
   endgenerate

   // ---------------- switch synchroniser ----------------
   logic [SW_WIDTH-1:0] sw_sync, sw_rise;
   assign sw_sync = sync_reg[SYNC_STAGES-1];
   assign sw_rise = sw_sync & ~sw_prev_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_reg[i] <= '0;
         sw_prev_reg <= '0;
      end else begin
         sync_reg[0] <= switches;
         for (int i = 1; i < SYNC_STAGES; i++) sync_reg[i] <= sync_reg[i-1];
         sw_prev_reg <= sw_sync;
      end
   end

   // ---------------- local registers and read data ----------------
   logic [15:0] local_rdata;

   always_comb begin
      local_rdata = 16'h0000;
      case (offset[1:0])
         2'd0: local_rdata = 16'(sw_sync);
         2'd1: local_rdata = 16'(irq_status_reg);
         2'd2: local_rdata = 16'(irq_mask_reg);
         default: local_rdata = {9'd0, err_idx_reg, 2'b00, err_um_reg, err_to_reg};
      endcase
   end

   always_comb begin
      data_out_next   = data_out_reg;
      serviced_next   = 1'b0;
      irq_status_next = irq_status_reg;
      irq_mask_next   = irq_mask_reg;
      err_to_next     = err_to_reg;
      err_um_next     = err_um_reg;
      err_idx_next    = err_idx_reg;

      if (idle && dec_local && bus.write_enable) begin
         case (offset[1:0])
            2'd1: irq_status_next = irq_status_reg & ~bus.data_in[SW_WIDTH-1:0];
            2'd2: irq_mask_next   = bus.data_in[SW_WIDTH-1:0];
            2'd3: begin
               if (bus.data_in[0]) err_to_next = 1'b0;
               if (bus.data_in[1]) err_um_next = 1'b0;
            end
            default: ;
         endcase
      end
      if (idle && dec_local && !bus.write_enable) begin
         serviced_next = 1'b1;
         data_out_next = local_rdata;
      end

      // Sets are applied after the W1C clears so a coincident event wins.
      irq_status_next = irq_status_next | sw_rise;

      if (idle && dec_unmapped) begin
         err_um_next = 1'b1;
         if (!bus.write_enable) begin
            serviced_next = 1'b1;
            data_out_next = 16'h0000;
         end
      end
      if (slot_done && !acc_wr) begin
         serviced_next = 1'b1;
         data_out_next = rdata_arr[acc_idx];
      end
      if (slot_timeout) begin
         err_to_next  = 1'b1;
         err_idx_next = acc_idx;
         if (!acc_wr) begin
            serviced_next = 1'b1;
            data_out_next = 16'hffff;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_out_reg   <= '0;
         serviced_reg   <= 1'b0;
         irq_status_reg <= '0;
         irq_mask_reg   <= '0;
         err_to_reg     <= 1'b0;
         err_um_reg     <= 1'b0;
         err_idx_reg    <= '0;
      end else begin
         data_out_reg   <= data_out_next;
         serviced_reg   <= serviced_next;
         irq_status_reg <= irq_status_next;
         irq_mask_reg   <= irq_mask_next;
         err_to_reg     <= err_to_next;
         err_um_reg     <= err_um_next;
         err_idx_reg    <= err_idx_next;
      end
   end

   assign bus.data_out      = data_out_reg;
   assign bus.serviced_read = serviced_reg;
   assign irq               = |(irq_status_reg & irq_mask_reg);
endmodule
